// File: rtl/s_machine_pkg.sv
// Shared definitions for the S-Machine core: opcodes, FSM states and
// instruction field extraction helpers.
package s_machine_pkg;

  // Helpers operate on a zero-extended instruction of this width.
  localparam int MAX_INSTR_W = 64;
  localparam int MAX_FIELD_W = 32;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_INC  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  function automatic logic [MAX_FIELD_W-1:0] field_mask(input int width);
    field_mask = (MAX_FIELD_W'(1'b1) << width) - MAX_FIELD_W'(1'b1);
  endfunction

  function automatic logic [3:0] instr_op(input logic [MAX_INSTR_W-1:0] w,
                                          input int reg_aw, input int data_w);
    instr_op = 4'(w >> (2 * reg_aw + data_w));
  endfunction

  function automatic logic [MAX_FIELD_W-1:0] instr_rd(input logic [MAX_INSTR_W-1:0] w,
                                                      input int reg_aw, input int data_w);
    instr_rd = MAX_FIELD_W'(w >> (reg_aw + data_w)) & field_mask(reg_aw);
  endfunction

  function automatic logic [MAX_FIELD_W-1:0] instr_rs(input logic [MAX_INSTR_W-1:0] w,
                                                      input int reg_aw, input int data_w);
    instr_rs = MAX_FIELD_W'(w >> data_w) & field_mask(reg_aw);
  endfunction

  function automatic logic [MAX_FIELD_W-1:0] instr_imm(input logic [MAX_INSTR_W-1:0] w,
                                                       input int data_w);
    instr_imm = MAX_FIELD_W'(w) & field_mask(data_w);
  endfunction

endpackage

// File: rtl/s_machine_alu.sv
// Combinational ALU: result plus carry/borrow and zero for opcodes LDI..XOR.
module s_machine_alu
  import s_machine_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] wide_s;

  // One extra bit holds carry-out for ADD/INC and borrow for SUB.
  always_comb begin
    wide_s = '0;
    case (op)
      OP_LDI:  wide_s = {1'b0, b};
      OP_ADD:  wide_s = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide_s = {1'b0, a} - {1'b0, b};
      OP_INC:  wide_s = {1'b0, a} + (DATA_W + 1)'(1'b1);
      OP_OR:   wide_s = {1'b0, a | b};
      OP_AND:  wide_s = {1'b0, a & b};
      OP_XOR:  wide_s = {1'b0, a ^ b};
      default: wide_s = '0;
    endcase
    result = wide_s[DATA_W-1:0];
    carry  = wide_s[DATA_W];
    zero   = (wide_s[DATA_W-1:0] == '0);
  end

endmodule

// File: rtl/s_machine_core.sv
// Multi-cycle S-Machine core: FSM, program counter, register file, flags and
// writable program RAM; two clocks per instruction (FETCH, EXEC).
module s_machine_core
  import s_machine_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int NREGS   = 4,
  parameter  int PC_W    = 8,
  localparam int REG_AW  = $clog2(NREGS),
  localparam int INSTR_W = 4 + 2 * REG_AW + DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               restart,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_wdata,
  input  logic [REG_AW-1:0]  dbg_sel,
  output logic [DATA_W-1:0]  dbg_data,
  output logic [PC_W-1:0]    count,
  output logic               flag_z,
  output logic               flag_c,
  output logic               halted,
  output logic               err
);

  state_e state_r, state_next_s;

  logic [INSTR_W-1:0] prog_mem_r [2**PC_W];
  logic [INSTR_W-1:0] ir_r;
  logic [DATA_W-1:0]  regs_r [NREGS];
  logic [PC_W-1:0]    pc_r;
  logic               z_r, c_r, err_r, halted_r;

  logic [3:0]         op_s;
  logic [REG_AW-1:0]  rd_s, rs_s;
  logic [DATA_W-1:0]  imm_s, alu_a_s, alu_b_s, alu_res_s;
  logic               alu_c_s, alu_z_s;
  logic [PC_W-1:0]    pc_inc_s, jmp_tgt_s;
  logic               prog_wr_ok_s;

  assign op_s  = instr_op(MAX_INSTR_W'(ir_r), REG_AW, DATA_W);
  assign rd_s  = REG_AW'(instr_rd(MAX_INSTR_W'(ir_r), REG_AW, DATA_W));
  assign rs_s  = REG_AW'(instr_rs(MAX_INSTR_W'(ir_r), REG_AW, DATA_W));
  assign imm_s = DATA_W'(instr_imm(MAX_INSTR_W'(ir_r), DATA_W));

  // Cast truncates or zero-extends the immediate to the PC width.
  assign jmp_tgt_s    = PC_W'(imm_s);
  assign pc_inc_s     = pc_r + PC_W'(1'b1);
  assign prog_wr_ok_s = (state_r == ST_IDLE) || (state_r == ST_HALT);

  assign dbg_data = regs_r[dbg_sel];
  assign count    = pc_r;
  assign flag_z   = z_r;
  assign flag_c   = c_r;
  assign err      = err_r;
  assign halted   = halted_r;

  // ALU operand select: LDI takes the immediate in place of rs.
  always_comb begin
    alu_a_s = regs_r[rd_s];
    if (op_s == OP_LDI) begin
      alu_b_s = imm_s;
    end else begin
      alu_b_s = regs_r[rs_s];
    end
  end

  s_machine_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_s),
    .a      (alu_a_s),
    .b      (alu_b_s),
    .result (alu_res_s),
    .carry  (alu_c_s),
    .zero   (alu_z_s)
  );

  // FSM state and halted indicator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      halted_r <= (state_next_s == ST_HALT);
    end
  end

  // Next-state decode; enable is deliberately not looked at in EXEC or HALT.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (enable) begin
          state_next_s = ST_EXEC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (op_s >= OP_HALT) begin
          state_next_s = ST_HALT;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_HALT: begin
        if (restart) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_HALT;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Program RAM write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (prog_we && prog_wr_ok_s) begin
      prog_mem_r[prog_addr] <= prog_wdata;
    end
  end

  // Fetch latch and EXEC commit of registers, flags, PC and error state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r  <= '0;
      z_r   <= 1'b0;
      c_r   <= 1'b0;
      err_r <= 1'b0;
      ir_r  <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      case (state_r)
        ST_FETCH: ir_r <= prog_mem_r[pc_r];
        ST_EXEC: begin
          case (op_s)
            OP_NOP: pc_r <= pc_inc_s;
            OP_LDI, OP_ADD, OP_SUB, OP_INC, OP_OR, OP_AND, OP_XOR: begin
              regs_r[rd_s] <= alu_res_s;
              z_r          <= alu_z_s;
              c_r          <= alu_c_s;
              pc_r         <= pc_inc_s;
            end
            OP_JMP:  pc_r <= jmp_tgt_s;
            OP_JZ:   pc_r <= z_r ? jmp_tgt_s : pc_inc_s;
            OP_HALT: pc_r <= pc_r;
            default: err_r <= 1'b1;
          endcase
        end
        ST_HALT: begin
          if (restart) begin
            pc_r  <= '0;
            z_r   <= 1'b0;
            c_r   <= 1'b0;
            err_r <= 1'b0;
          end
        end
        default: ir_r <= ir_r;
      endcase
    end
  end

endmodule

// File: tb/tb_s_machine_core.sv
// Directed bench for s_machine_core: table-driven programs plus hand-written
// sequences for restart, enable, reset and PC wrap behaviour.
module tb_s_machine_core;
  import s_machine_pkg::*;

  logic        clk, rst_n;
  logic        enable, restart, prog_we;
  logic [7:0]  prog_addr;
  logic [15:0] prog_wdata;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data, count;
  logic        flag_z, flag_c, halted, err;

  logic        enable4, restart4, prog_we4;
  logic [3:0]  prog_addr4;
  logic [15:0] prog_wdata4;
  logic [1:0]  dbg_sel4;
  logic [7:0]  dbg_data4;
  logic [3:0]  count4;
  logic        flag_z4, flag_c4, halted4, err4;

  int pass_cnt = 0;
  int total_cnt = 0;

  s_machine_core #(.DATA_W(8), .NREGS(4), .PC_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .count(count),
    .flag_z(flag_z), .flag_c(flag_c), .halted(halted), .err(err)
  );

  s_machine_core #(.DATA_W(8), .NREGS(4), .PC_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable4), .restart(restart4),
    .prog_we(prog_we4), .prog_addr(prog_addr4), .prog_wdata(prog_wdata4),
    .dbg_sel(dbg_sel4), .dbg_data(dbg_data4), .count(count4),
    .flag_z(flag_z4), .flag_c(flag_c4), .halted(halted4), .err(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] instr;
    logic [1:0]  sel;
    logic [7:0]  val;
    logic        z;
    logic        c;
    logic [7:0]  cnt;
    logic        hlt;
  } vec_t;

  vec_t vecs [20];

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [7:0] addr, input logic [15:0] data);
    prog_we    = 1'b1;
    prog_addr  = addr;
    prog_wdata = data;
    tick(1);
    prog_we    = 1'b0;
  endtask

  task automatic load4(input logic [3:0] addr, input logic [15:0] data);
    prog_we4    = 1'b1;
    prog_addr4  = addr;
    prog_wdata4 = data;
    tick(1);
    prog_we4    = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
  endtask

  // Load a program segment from the table, run it from PC 0 and check every commit.
  task automatic run_seg(input int first, input int n);
    enable = 1'b0;
    for (int i = 0; i < n; i++) begin
      load(vecs[first + i].addr, vecs[first + i].instr);
    end
    enable = 1'b1;
    for (int i = 0; i < n; i++) begin
      dbg_sel = vecs[first + i].sel;
      tick((i == 0) ? 3 : 2);
      check($sformatf("v%0d_reg", first + i), 32'(dbg_data), 32'(vecs[first + i].val));
      check($sformatf("v%0d_z", first + i), 32'(flag_z), 32'(vecs[first + i].z));
      check($sformatf("v%0d_c", first + i), 32'(flag_c), 32'(vecs[first + i].c));
      check($sformatf("v%0d_count", first + i), 32'(count), 32'(vecs[first + i].cnt));
      check($sformatf("v%0d_halted", first + i), 32'(halted), 32'(vecs[first + i].hlt));
    end
    enable = 1'b0;
  endtask

  initial begin
    // Main arithmetic/logic program.
    vecs[0]  = '{8'd0, enc(OP_LDI, 2'd0, 2'd0, 8'd5),   2'd0, 8'd5,   1'b0, 1'b0, 8'd1, 1'b0};
    vecs[1]  = '{8'd1, enc(OP_LDI, 2'd1, 2'd0, 8'd3),   2'd1, 8'd3,   1'b0, 1'b0, 8'd2, 1'b0};
    vecs[2]  = '{8'd2, enc(OP_ADD, 2'd0, 2'd1, 8'd0),   2'd0, 8'd8,   1'b0, 1'b0, 8'd3, 1'b0};
    vecs[3]  = '{8'd3, enc(OP_SUB, 2'd0, 2'd1, 8'd0),   2'd0, 8'd5,   1'b0, 1'b0, 8'd4, 1'b0};
    vecs[4]  = '{8'd4, enc(OP_INC, 2'd1, 2'd0, 8'd0),   2'd1, 8'd4,   1'b0, 1'b0, 8'd5, 1'b0};
    vecs[5]  = '{8'd5, enc(OP_OR,  2'd0, 2'd1, 8'd0),   2'd0, 8'd5,   1'b0, 1'b0, 8'd6, 1'b0};
    vecs[6]  = '{8'd6, enc(OP_AND, 2'd0, 2'd1, 8'd0),   2'd0, 8'd4,   1'b0, 1'b0, 8'd7, 1'b0};
    vecs[7]  = '{8'd7, enc(OP_XOR, 2'd0, 2'd1, 8'd0),   2'd0, 8'd0,   1'b1, 1'b0, 8'd8, 1'b0};
    vecs[8]  = '{8'd8, enc(OP_HALT, 2'd0, 2'd0, 8'd0),  2'd0, 8'd0,   1'b1, 1'b0, 8'd8, 1'b1};
    // Carry and borrow.
    vecs[9]  = '{8'd0, enc(OP_LDI, 2'd0, 2'd0, 8'hFF),  2'd0, 8'hFF,  1'b0, 1'b0, 8'd1, 1'b0};
    vecs[10] = '{8'd1, enc(OP_INC, 2'd0, 2'd0, 8'd0),   2'd0, 8'h00,  1'b1, 1'b1, 8'd2, 1'b0};
    vecs[11] = '{8'd2, enc(OP_LDI, 2'd1, 2'd0, 8'd1),   2'd1, 8'h01,  1'b0, 1'b0, 8'd3, 1'b0};
    vecs[12] = '{8'd3, enc(OP_SUB, 2'd0, 2'd1, 8'd0),   2'd0, 8'hFF,  1'b0, 1'b1, 8'd4, 1'b0};
    vecs[13] = '{8'd4, enc(OP_HALT, 2'd0, 2'd0, 8'd0),  2'd0, 8'hFF,  1'b0, 1'b1, 8'd4, 1'b1};
    // JZ taken / not taken, JMP, flags preserved across jumps.
    vecs[14] = '{8'd0, enc(OP_LDI, 2'd2, 2'd0, 8'd0),   2'd2, 8'd0,   1'b1, 1'b0, 8'd1, 1'b0};
    vecs[15] = '{8'd1, enc(OP_JZ,  2'd0, 2'd0, 8'd4),   2'd2, 8'd0,   1'b1, 1'b0, 8'd4, 1'b0};
    vecs[16] = '{8'd4, enc(OP_LDI, 2'd3, 2'd0, 8'd9),   2'd3, 8'd9,   1'b0, 1'b0, 8'd5, 1'b0};
    vecs[17] = '{8'd5, enc(OP_JZ,  2'd0, 2'd0, 8'd2),   2'd3, 8'd9,   1'b0, 1'b0, 8'd6, 1'b0};
    vecs[18] = '{8'd6, enc(OP_JMP, 2'd0, 2'd0, 8'd3),   2'd3, 8'd9,   1'b0, 1'b0, 8'd3, 1'b0};
    vecs[19] = '{8'd3, enc(OP_HALT, 2'd0, 2'd0, 8'd0),  2'd3, 8'd9,   1'b0, 1'b0, 8'd3, 1'b1};

    rst_n = 1'b0; enable = 1'b0; restart = 1'b0; prog_we = 1'b0;
    prog_addr = 8'd0; prog_wdata = 16'd0; dbg_sel = 2'd0;
    enable4 = 1'b0; restart4 = 1'b0; prog_we4 = 1'b0;
    prog_addr4 = 4'd0; prog_wdata4 = 16'd0; dbg_sel4 = 2'd0;
    tick(2);

    check("rst_count", 32'(count), 32'd0);
    check("rst_z", 32'(flag_z), 32'd0);
    check("rst_c", 32'(flag_c), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    for (int r = 0; r < 4; r++) begin
      dbg_sel = 2'(r);
      #1;
      check($sformatf("rst_r%0d", r), 32'(dbg_data), 32'd0);
    end
    check("rst_count4", 32'(count4), 32'd0);
    rst_n = 1'b1;
    tick(1);

    run_seg(0, 9);

    // Restart clears PC, flags and err but keeps registers.
    pulse_restart();
    dbg_sel = 2'd1;
    #1;
    check("rs1_count", 32'(count), 32'd0);
    check("rs1_z", 32'(flag_z), 32'd0);
    check("rs1_halted", 32'(halted), 32'd0);
    check("rs1_r1", 32'(dbg_data), 32'd4);

    run_seg(9, 5);
    pulse_restart();
    run_seg(14, 6);
    pulse_restart();

    // Illegal opcode 0xC at address 2.
    load(8'd0, enc(OP_LDI, 2'd2, 2'd0, 8'd7));
    load(8'd1, enc(OP_NOP, 2'd0, 2'd0, 8'd0));
    load(8'd2, 16'hC000);
    enable = 1'b1;
    tick(7);
    enable = 1'b0;
    dbg_sel = 2'd2;
    #1;
    check("ill_err", 32'(err), 32'd1);
    check("ill_halted", 32'(halted), 32'd1);
    check("ill_count", 32'(count), 32'd2);
    check("ill_r2", 32'(dbg_data), 32'd7);
    restart = 1'b1;
    tick(3);
    restart = 1'b0;
    check("ill_rs_count", 32'(count), 32'd0);
    check("ill_rs_err", 32'(err), 32'd0);
    check("ill_rs_halted", 32'(halted), 32'd0);
    check("ill_rs_r2", 32'(dbg_data), 32'd7);
    dbg_sel = 2'd3;
    #1;
    check("ill_rs_r3", 32'(dbg_data), 32'd9);

    // Enable dropped in FETCH, then dropped during EXEC.
    load(8'd0, enc(OP_LDI, 2'd0, 2'd0, 8'd1));
    load(8'd1, enc(OP_LDI, 2'd0, 2'd0, 8'd2));
    load(8'd2, enc(OP_LDI, 2'd0, 2'd0, 8'd3));
    load(8'd3, enc(OP_HALT, 2'd0, 2'd0, 8'd0));
    dbg_sel = 2'd0;
    enable = 1'b1;
    tick(3);
    enable = 1'b0;
    tick(4);
    check("en_f_count", 32'(count), 32'd1);
    check("en_f_r0", 32'(dbg_data), 32'd1);
    check("en_f_halted", 32'(halted), 32'd0);
    enable = 1'b1;
    tick(2);
    enable = 1'b0;
    tick(4);
    check("en_x_count", 32'(count), 32'd2);
    check("en_x_r0", 32'(dbg_data), 32'd2);

    // Program writes while running must be ignored.
    enable = 1'b1;
    tick(1);
    prog_we = 1'b1;
    prog_addr = 8'd3;
    prog_wdata = enc(OP_LDI, 2'd0, 2'd0, 8'hAA);
    tick(2);
    prog_we = 1'b0;
    tick(2);
    enable = 1'b0;
    check("we_run_halted", 32'(halted), 32'd1);
    check("we_run_count", 32'(count), 32'd3);
    check("we_run_r0", 32'(dbg_data), 32'd3);
    pulse_restart();

    // Asynchronous reset during EXEC of ADD.
    load(8'd0, enc(OP_LDI, 2'd0, 2'd0, 8'h11));
    load(8'd1, enc(OP_LDI, 2'd1, 2'd0, 8'h22));
    load(8'd2, enc(OP_ADD, 2'd0, 2'd1, 8'd0));
    load(8'd3, enc(OP_HALT, 2'd0, 2'd0, 8'd0));
    dbg_sel = 2'd0;
    enable = 1'b1;
    tick(3);
    check("rx_pre_r0", 32'(dbg_data), 32'h11);
    tick(3);
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check("rx_count", 32'(count), 32'd0);
    check("rx_r0", 32'(dbg_data), 32'd0);
    dbg_sel = 2'd1;
    #1;
    check("rx_r1", 32'(dbg_data), 32'd0);
    tick(1);
    dbg_sel = 2'd0;
    #1;
    check("rx_hold_r0", 32'(dbg_data), 32'd0);
    check("rx_hold_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // PC wrap on the 4-bit-PC instance running only NOPs.
    for (int a = 0; a < 16; a++) begin
      load4(4'(a), 16'h0000);
    end
    enable4 = 1'b1;
    tick(31);
    check("wrap_count15", 32'(count4), 32'd15);
    tick(2);
    check("wrap_count0", 32'(count4), 32'd0);
    tick(2);
    check("wrap_count1", 32'(count4), 32'd1);
    check("wrap_halted", 32'(halted4), 32'd0);
    enable4 = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/s_machine_core.md
# s_machine_core

Parametrised successor to the S-Machine CPU: a multi-cycle fetch/execute core with generic data width, register-file size and program depth. Adds a writable program memory, flags, conditional jump and halt, and keeps the `count` program-counter output. Sits at the top of the S-Machine datapath; benches load a program, enable it and check state via the debug read port.

## Interface
- `DATA_W`, 8: register/ALU width (≥4).
- `NREGS`, 4: register count (power of 2, ≥2); `REG_AW = clog2(NREGS)`.
- `PC_W`, 8: program-counter width; program depth = 2^PC_W.
- Instruction width `INSTR_W = 4 + 2*REG_AW + DATA_W`, fields MSB→LSB: `op[3:0]`, `rd`, `rs`, `imm`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run permission, sampled each cycle.
- `restart` in 1: one-cycle pulse, leaves HALT.
- `prog_we` in 1: program-memory write strobe.
- `prog_addr` in PC_W: program write address.
- `prog_wdata` in INSTR_W: program write data.
- `dbg_sel` in REG_AW: register selected for debug read.
- `dbg_data` out DATA_W: combinational value of `regs[dbg_sel]`.
- `count` out PC_W: current program counter.
- `flag_z`, `flag_c` out 1: zero and carry/borrow flags.
- `halted` out 1: core in HALT.
- `err` out 1: sticky illegal-opcode indicator.

## Operation
- States: IDLE, FETCH, EXEC, HALT. Reset → IDLE, `count`=0, all regs=0, flags=0, `err`=0.
- IDLE: `enable`=1 → FETCH.
- FETCH: synchronous read of `prog[count]`; `enable`=0 → IDLE (PC held); else → EXEC.
- EXEC: decode the read word, update state, → FETCH. `enable` is not sampled in EXEC.
- Opcodes:
  - 0 NOP.
  - 1 LDI: rd=imm.
  - 2 ADD: rd=rd+rs.
  - 3 SUB: rd=rd−rs.
  - 4 INC: rd=rd+1.
  - 5 OR, 6 AND, 7 XOR: rd=rd op rs.
  - 8 JMP: PC=imm[PC_W-1:0] (zero-extended if PC_W>DATA_W).
  - 9 JZ: jump as JMP if `flag_z`, else PC+1.
  - A HALT.
  - B–F illegal: set `err`, enter HALT.
- Non-jump opcodes advance PC+1. PC wraps from 2^PC_W−1 to 0 silently.
- Arithmetic is modulo 2^DATA_W.
  - ADD/INC: C = carry-out. SUB: C = borrow (rs>rd unsigned).
  - Logic ops and LDI: C cleared.
  - Z = (result==0) for opcodes 1–7. Jumps, NOP and HALT preserve flags.
- HALT: PC points at the HALT instruction (not incremented); `halted`=1. `restart` → IDLE with PC=0, flags=0, `err`=0; registers retained. `enable` is ignored in HALT.
- Program writes:
  - Accepted only in IDLE or HALT; ignored in FETCH/EXEC.
  - Program memory is not reset (contents undefined until written).
- `restart` outside HALT is ignored.

## Timing
- Two cycles per executed instruction (FETCH, EXEC).
- Register, flag and PC updates become visible on the clock edge ending EXEC.
- From IDLE with `enable` high: first instruction result is visible 3 edges later (IDLE→FETCH, FETCH→EXEC, EXEC commit).
- A program write in cycle n can be fetched from cycle n+1.
- `rst_n` low at any point, including mid-EXEC: all outputs return to reset values immediately; no partial commit.
- `enable` dropping during EXEC finishes that instruction, then stops in FETCH→IDLE.

## Structure
- Package `s_machine_pkg`: opcode constants (OP_NOP … OP_HALT), state enum, field-extraction helper functions parametrised by REG_AW/DATA_W.
- One sub-module `s_machine_alu`: combinational; inputs op, a, b; outputs result, carry, zero. Core holds the FSM, PC, register file and program RAM.

## Test plan
- DATA_W=8. Program: LDI r0,5; LDI r1,3; ADD r0,r1; SUB r0,r1; INC r1; OR r0,r1; AND r0,r1; XOR r0,r1; HALT.
  - Required: r0 = 8, 5, 5, 5, 4, 0; r1=4; final Z=1, C=0.
  - `halted`=1 with `count`=8.
- Carry/borrow: LDI r0,0xFF; INC r0 → r0=0x00, Z=1, C=1. Then SUB r0,r1 with r1=1 → r0=0xFF, C=1, Z=0.
- Branch/wrap: PC_W=4 with NOPs at 0–15 (no HALT) → `count` wraps 15→0. Separately, JZ taken when Z=1 and not taken when Z=0.
- Illegal opcode 0xC at addr 2 → `err`=1, `halted`=1, `count`=2. `restart` → `count`=0, `err`=0, regs unchanged.
- Enable/reset:
  - `enable` low mid-program → PC frozen in IDLE, no register change.
  - `rst_n` asserted during EXEC of ADD → all regs 0, `count`=0 immediately.
  - `prog_we` while running has no effect on program contents.
